mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Single-port RAM arbiter/sequencer that shares one memory port between the instruction-fetch requester (iREN) and the data requester (dREN/dWEN).
- Sits between the request unit / datapath and the RAM.
- Latches each granted request, sequences it against the RAM's variable-latency ramstate handshake, and returns one-cycle ihit/dhit pulses with registered load data.
- Data has priority, bounded by an anti-starvation limit, and a watchdog aborts hung accesses.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while iREN is pending before instruction is forced.
- TIMEOUT, 64: busy-state cycles without ACCESS before abort.
- ERR_WORD, 32'hBAD1BAD1: load value returned on error or timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request, held until ihit.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request, held until dhit.
- dWEN  in  1  data write request, held until dhit.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- ihit  out  1  one-cycle instruction completion pulse.
- dhit  out  1  one-cycle data completion pulse.
- iload  out  32  fetched instruction, valid when ihit.
- dload  out  32  read data, valid when dhit.
- merr  out  1  with a hit: access failed (RAM ERROR or timeout).
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Behaviour:
- Clock and reset: one clock CLK. RST is synchronous and active-high; it is sampled only on the CLK rising edge.
- Reset values: state=IDLE; all outputs 0 (ihit, dhit, merr, iload, dload, ramREN, ramWEN, ramaddr, ramstore); dstreak=0; timer=0.
- RST asserted mid-access: same result, next edge state=IDLE, RAM strobes drop. No hit is issued for the aborted access.
- FSM states are IDLE, DBUSY, IBUSY, DONE.
- IDLE: RAM strobes low. Each cycle:
  - Data request is dREN|dWEN.
  - If a data request is present and not (iREN && dstreak==MAX_DSTREAK): go to DBUSY.
  - Else if iREN: go to IBUSY.
  - Else: stay in IDLE.
- Grant latch: on entering a busy state, latch addr (bits [1:0] forced to 00), dstore, and op.
  - dWEN && dREN together: treated as a write.
- dstreak counter:
  - Increments on a data grant while iREN=1, saturating at MAX_DSTREAK.
  - Clears on any instruction grant, or on any IDLE cycle with iREN=0.
- DBUSY/IBUSY: ramaddr/ramstore come from the latch. ramREN = read op, ramWEN = write op. Requester inputs are ignored while busy.
  - ramstate==ACCESS: go to DONE. Capture ramload into iload/dload (reads only). merr=0.
  - ramstate==ERROR, or timer==TIMEOUT-1: go to DONE. Load reg=ERR_WORD, merr=1.
  - Otherwise: timer++.
  - timer clears on entry to each busy state.
- DONE: exactly one cycle.
  - Asserts ihit or dhit for the completed source; merr holds for that cycle.
  - RAM strobes low. Next state IDLE.
  - The requester still asserts its request this cycle; this is not re-granted because DONE does not arbitrate.
- Latency: request seen in IDLE at cycle t → RAM strobe at t+1. ACCESS at t+k (k≥1) → hit at t+k+1. Minimum request-to-hit latency is 2 cycles, plus 1 idle cycle between back-to-back accesses.
- Write completions: dhit=1, dload unchanged.
- iload/dload hold their last value outside hits. ihit and dhit are never asserted together.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (FREE, BUSY, ACCESS, ERROR). Also add arbstate_t (IDLE, DBUSY, IBUSY, DONE).
- Single module, no sub-modules. The timeout counter is inline.

Test Plan:
1. iREN=1, iaddr=0x40; RAM gives ACCESS on the 3rd busy cycle with ramload=0x8C010004 → ramREN high 3 cycles, ihit pulses 1 cycle, iload=0x8C010004, merr=0.
2. dWEN=1, daddr=0x103, dstore=0xDEADBEEF, RAM ACCESS after 1 cycle → ramaddr=0x100, ramWEN=1, ramstore=0xDEADBEEF, dhit one pulse, ihit=0.
3. iREN and dREN held continuously, RAM always ACCESS in 1 cycle → grant order D,D,D,D,I,D,D,D,D,I…; no hit is re-granted in DONE.
4. dREN=1, ramstate stuck BUSY → dhit at cycle TIMEOUT+1 after the grant, dload=0xBAD1BAD1, merr=1. ramstate=ERROR instead → same result, next cycle.
5. RST=1 during IBUSY → next edge all outputs 0, state IDLE, no ihit; with iREN still high after release, a fresh grant occurs.
6. dREN=dWEN=1 → treated as a write (ramWEN=1, ramREN=0), dhit with dload unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Types shared by the CPU memory subsystem: data word, RAM handshake state,
// arbiter FSM state and the latched grant record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY, DONE} arbstate_t;

  typedef struct packed {
    word_t addr;
    word_t wdata;
    logic  wr;
    logic  instr;
  } grant_t;

  function automatic word_t word_align(input word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access: data-first
// arbitration with an anti-starvation streak limit and a hung-access watchdog.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter word_t       ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     iload,
  output word_t     dload,
  output logic      merr,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int unsigned   SW         = $clog2(MAX_DSTREAK + 1);
  localparam int unsigned   TW         = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arbstate_t     state_q, state_d;
  grant_t        grant_q, grant_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic [TW-1:0] timer_q, timer_d;
  word_t         iload_q, iload_d;
  word_t         dload_q, dload_d;
  logic          err_q, err_d;

  logic data_req;
  logic busy;

  assign data_req = dREN | dWEN;
  assign busy     = (state_q == DBUSY) || (state_q == IBUSY);

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    if (RST) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      dstreak_q <= '0;
      timer_q   <= '0;
      iload_q   <= '0;
      dload_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      dstreak_q <= dstreak_d;
      timer_q   <= timer_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    dstreak_d = dstreak_q;
    timer_d   = timer_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (data_req && !(iREN && dstreak_q == STREAK_MAX)) begin
          state_d = DBUSY;
          grant_d = '{addr: word_align(daddr), wdata: dstore, wr: dWEN, instr: 1'b0};
          timer_d = '0;
          if (!iREN)
            dstreak_d = '0;
          else if (dstreak_q != STREAK_MAX)
            dstreak_d = dstreak_q + 1'b1;
        end else if (iREN) begin
          state_d   = IBUSY;
          grant_d   = '{addr: word_align(iaddr), wdata: dstore, wr: 1'b0, instr: 1'b1};
          timer_d   = '0;
          dstreak_d = '0;
        end else begin
          dstreak_d = '0;
        end
      end

      DBUSY, IBUSY: begin
        // Writes never touch the load registers, even when they fail.
        if (ramstate == ACCESS) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (!grant_q.wr) begin
            if (grant_q.instr) iload_d = ramload;
            else               dload_d = ramload;
          end
        end else if (ramstate == ERROR || timer_q == TIMER_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!grant_q.wr) begin
            if (grant_q.instr) iload_d = ERR_WORD;
            else               dload_d = ERR_WORD;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ihit     = (state_q == DONE) &&  grant_q.instr;
  assign dhit     = (state_q == DONE) && !grant_q.instr;
  assign merr     = (state_q == DONE) &&  err_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = busy && !grant_q.wr;
  assign ramWEN   = busy &&  grant_q.wr;
  assign ramaddr  = grant_q.addr;
  assign ramstore = grant_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, streak and reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int    MAX_DSTREAK = 4;
  localparam int    TIMEOUT     = 64;
  localparam word_t ERR_WORD    = 32'hBAD1BAD1;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      ihit, dhit, merr, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .MAX_DSTREAK(MAX_DSTREAK),
    .TIMEOUT    (TIMEOUT),
    .ERR_WORD   (ERR_WORD)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .ihit    (ihit),
    .dhit    (dhit),
    .iload   (iload),
    .dload   (dload),
    .merr    (merr),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string     name;
    logic      iren, dren, dwen;
    word_t     addr, store, load;
    int        busy;
    ramstate_t fin;
    logic      exp_i;
    word_t     exp_ramaddr;
    logic      exp_wen;
    int        exp_strobes;
    word_t     exp_load;
    logic      exp_merr;
  } vec_t;

  vec_t vecs[8];

  // One access: present the request in an idle cycle, answer BUSY for v.busy
  // strobe cycles then v.fin, and compare what the arbiter did.
  task automatic run_vec(input vec_t v);
    int    cyc = 0, strobes = 0;
    logic  got_hit = 1'b0, hi = 1'b0, hd = 1'b0, mer = 1'b0, rw = 1'b0, rr = 1'b0;
    word_t ra = '0, rs = '0, ld = '0;
    iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
    iaddr = v.addr; daddr = v.addr; dstore = v.store; ramload = v.load;
    while (!got_hit && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
      if (ramREN || ramWEN) begin
        if (strobes == 0) begin
          ra = ramaddr; rs = ramstore; rw = ramWEN; rr = ramREN;
        end
        strobes++;
        ramstate = (strobes <= v.busy) ? BUSY : v.fin;
      end else begin
        ramstate = FREE;
      end
      if (ihit || dhit) begin
        got_hit = 1'b1; hi = ihit; hd = dhit; mer = merr;
        ld = ihit ? iload : dload;
      end
    end
    check({v.name, " hit_seen"}, got_hit, 1'b1);
    check({v.name, " ihit"}, hi, v.exp_i);
    check({v.name, " dhit"}, hd, !v.exp_i);
    check({v.name, " ramaddr"}, ra, v.exp_ramaddr);
    check({v.name, " ramWEN"}, rw, v.exp_wen);
    check({v.name, " ramREN"}, rr, !v.exp_wen);
    if (v.exp_wen) check({v.name, " ramstore"}, rs, v.store);
    check({v.name, " strobe_cycles"}, strobes, v.exp_strobes);
    check({v.name, " latency"}, cyc, v.exp_strobes + 1);
    check({v.name, " load"}, ld, v.exp_load);
    check({v.name, " merr"}, mer, v.exp_merr);
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    grants, cyc, last_rise;
    logic  prev_strobe, is_i, saw_ihit;
    logic  ipend, dpend, i_drop, d_drop, cur_i, inj_err, exp_hit;
    logic  prev_idle, prev_i, prev_d, strobe, hit;
    int    dk, streak, busy_left;
    word_t ia, da, ds, exp_iload, exp_dload;
    word_t exp_mem[16], ram_mem[16];

    vecs[0] = '{"ifetch",   1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        32'h8C010004, 2,    ACCESS,
                1'b1, 32'h40,  1'b0, 3,  32'h8C010004, 1'b0};
    vecs[1] = '{"dwrite",   1'b0, 1'b0, 1'b1, 32'h103, 32'hDEADBEEF, 32'h11111111, 0,    ACCESS,
                1'b0, 32'h100, 1'b1, 1,  32'h0,        1'b0};
    vecs[2] = '{"dread_err",1'b0, 1'b1, 1'b0, 32'h20,  32'h0,        32'h22222222, 0,    ERROR,
                1'b0, 32'h20,  1'b0, 1,  ERR_WORD,     1'b1};
    vecs[3] = '{"d_both",   1'b0, 1'b1, 1'b1, 32'h26,  32'h12345678, 32'h33333333, 1,    ACCESS,
                1'b0, 32'h24,  1'b1, 2,  ERR_WORD,     1'b0};
    vecs[4] = '{"dread",    1'b0, 1'b1, 1'b0, 32'h2B,  32'h0,        32'hCAFEF00D, 1,    ACCESS,
                1'b0, 32'h28,  1'b0, 2,  32'hCAFEF00D, 1'b0};
    vecs[5] = '{"ifetch_err",1'b1,1'b0, 1'b0, 32'h7F,  32'h0,        32'h44444444, 2,    ERROR,
                1'b1, 32'h7C,  1'b0, 3,  ERR_WORD,     1'b1};
    vecs[6] = '{"dtimeout", 1'b0, 1'b1, 1'b0, 32'h30,  32'h0,        32'h55555555, 1000, ACCESS,
                1'b0, 32'h30,  1'b0, TIMEOUT, ERR_WORD, 1'b1};
    vecs[7] = '{"ifetch2",  1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        32'h0000ABCD, 0,    ACCESS,
                1'b1, 32'h44,  1'b0, 1,  32'h0000ABCD, 1'b0};

    do_reset();
    check("reset ihit", ihit, 1'b0);
    check("reset dhit", dhit, 1'b0);
    check("reset ramREN", ramREN, 1'b0);
    check("reset ramaddr", ramaddr, 32'h0);
    check("reset dload", dload, 32'h0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both requesters held, RAM answers at once: D,D,D,D,I repeating, 3 cycles apart.
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h80; daddr = 32'h90; ramload = 32'h0F0F0F0F;
    grants = 0; cyc = 0; last_rise = 0; prev_strobe = 1'b0;
    while (grants < 15 && cyc < 500) begin
      @(posedge CLK); #1;
      cyc++;
      if (ramREN && !prev_strobe) begin
        is_i = (ramaddr == 32'h80);
        check($sformatf("streak grant%0d is_instr", grants), is_i, (grants % 5) == 4);
        if (grants > 0) check($sformatf("streak grant%0d spacing", grants), cyc - last_rise, 3);
        last_rise = cyc;
        grants++;
      end
      prev_strobe = ramREN;
      ramstate = ramREN ? ACCESS : FREE;
    end
    check("streak grants_done", grants, 15);
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    @(posedge CLK); #1;

    // Reset while an instruction fetch is stuck in the busy state.
    iREN = 1'b1; iaddr = 32'h60; ramload = 32'h0000600D;
    cyc = 0;
    while (!ramREN && cyc < 20) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check("rst strobe_reached", ramREN, 1'b1);
    ramstate = BUSY;
    @(posedge CLK); #1;
    RST = 1'b1; ramstate = FREE;
    @(posedge CLK); #1;
    check("rst ihit", ihit, 1'b0);
    check("rst dhit", dhit, 1'b0);
    check("rst merr", merr, 1'b0);
    check("rst iload", iload, 32'h0);
    check("rst dload", dload, 32'h0);
    check("rst ramREN", ramREN, 1'b0);
    check("rst ramWEN", ramWEN, 1'b0);
    check("rst ramaddr", ramaddr, 32'h0);
    check("rst ramstore", ramstore, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("rst regrant ihit_quiet", ihit, 1'b0);
    check("rst regrant ramREN", ramREN, 1'b1);
    check("rst regrant ramaddr", ramaddr, 32'h60);
    ramstate = ACCESS;
    @(posedge CLK); #1;
    ramstate = FREE;
    check("rst regrant ihit", ihit, 1'b1);
    check("rst regrant iload", iload, 32'h0000600D);
    @(posedge CLK); #1;
    iREN = 1'b0;

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      exp_mem[k] = 32'hA5000000 + word_t'(k * 32'h111);
      ram_mem[k] = exp_mem[k];
    end
    ipend = 1'b0; dpend = 1'b0; i_drop = 1'b0; d_drop = 1'b0;
    cur_i = 1'b0; inj_err = 1'b0; exp_hit = 1'b0; busy_left = 0; streak = 0; dk = 0;
    ia = '0; da = '0; ds = '0; exp_iload = '0; exp_dload = '0;
    prev_idle = 1'b1; prev_i = 1'b0; prev_d = 1'b0; saw_ihit = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      strobe = ramREN | ramWEN;
      hit    = ihit | dhit;
      check("rnd hit_timing", hit, exp_hit);
      if (hit) begin
        check("rnd hit_exclusive", ihit & dhit, 1'b0);
        check("rnd hit_source", ihit, cur_i);
        check("rnd merr", merr, inj_err);
        if (cur_i) begin
          exp_iload = inj_err ? ERR_WORD : exp_mem[ia[5:2]];
          check("rnd iload", iload, exp_iload);
          saw_ihit = 1'b1;
        end else begin
          if (dk == 0) exp_dload = inj_err ? ERR_WORD : exp_mem[da[5:2]];
          else if (!inj_err) exp_mem[da[5:2]] = ds;
          check("rnd dload", dload, exp_dload);
        end
      end

      if (prev_idle) begin
        if (prev_i || prev_d) begin
          cur_i = !(prev_d && !(prev_i && streak == MAX_DSTREAK));
          if (cur_i)       streak = 0;
          else if (prev_i) streak = (streak + 1 > MAX_DSTREAK) ? MAX_DSTREAK : streak + 1;
          else             streak = 0;
          check("rnd grant_strobe", strobe, 1'b1);
          check("rnd grant_ramWEN", ramWEN, cur_i ? 1'b0 : (dk != 0));
          check("rnd grant_ramaddr", ramaddr, (cur_i ? ia : da) & ~32'h3);
          if (!cur_i && dk != 0) check("rnd grant_ramstore", ramstore, ds);
          busy_left = $urandom_range(0, 3);
          inj_err   = ($urandom_range(0, 7) == 0);
        end else begin
          check("rnd idle_no_strobe", strobe, 1'b0);
          streak = 0;
        end
      end

      exp_hit = 1'b0;
      if (strobe) begin
        if (busy_left > 0) begin
          ramstate = BUSY;
          busy_left--;
        end else begin
          exp_hit = 1'b1;
          if (inj_err) begin
            ramstate = ERROR;
          end else begin
            ramstate = ACCESS;
            if (ramWEN) ram_mem[ramaddr[5:2]] = ramstore;
            else        ramload = ram_mem[ramaddr[5:2]];
          end
        end
      end else begin
        ramstate = FREE;
        ramload  = $urandom;
      end

      if (i_drop) ipend = 1'b0;
      if (d_drop) dpend = 1'b0;
      i_drop = hit && cur_i;
      d_drop = hit && !cur_i;
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1'b1;
        ia    = $urandom_range(0, 63);
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1'b1;
        da    = $urandom_range(0, 63);
        ds    = $urandom;
        dk    = $urandom_range(0, 2);
      end
      iREN   = ipend;
      iaddr  = ia;
      dREN   = dpend && (dk != 1);
      dWEN   = dpend && (dk != 0);
      daddr  = da;
      dstore = ds;

      prev_idle = !strobe && !hit;
      prev_i    = iREN;
      prev_d    = dREN | dWEN;
    end
    check("rnd saw_instruction_hit", saw_ihit, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
